// File: rtl/guess_round_ctrl.sv
// Round sequencer for the number-guessing game: target generation, countdown, guess checking.
// Optional magnitude hints are built only when GUESS_HINT_EN is defined.
module guess_round_ctrl #(
    parameter int         ROUND_TIME       = 30,
    parameter int         TICK_DIV         = 50_000_000,
    parameter int         ROUNDS_PER_LEVEL = 5,
    parameter logic [9:0] LFSR_SEED        = 10'h2A5
) (
    input  logic       clk,
    input  logic       restart_n,
    input  logic       start,
    input  logic [1:0] max_digit,
    input  logic [2:0] max_incorrect,
    input  logic       confirm_btn,
    input  logic [9:0] guess,
    output logic [6:0] timer,
    output logic [2:0] incorrect_guesses,
    output logic [2:0] round,
    output logic [9:0] target,
    output logic       correct,
    output logic       wrong,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       guess_high,
    output logic       guess_low
);

    localparam int              PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX    = PW'(TICK_DIV - 1);
    localparam logic [6:0]      ROUND_TIME_V = 7'(ROUND_TIME);
    localparam logic [2:0]      ROUNDS_V     = 3'(ROUNDS_PER_LEVEL);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, CHECK, DONE} state_t;

    state_t         state_reg, state_next;
    logic [9:0]     lfsr_reg, lfsr_next;
    logic [PW-1:0]  presc_reg, presc_next;
    logic [6:0]     timer_reg, timer_next;
    logic [2:0]     inc_reg, inc_next;
    logic [2:0]     round_reg, round_next;
    logic [9:0]     target_reg, target_next;
    logic [9:0]     guess_reg, guess_next;
    logic           correct_reg, correct_next;
    logic           wrong_reg, wrong_next;
    logic           timeout_reg, timeout_next;
    logic           conf_q_reg;

    logic           conf_edge;
    logic [9:0]     cand;
    logic           cand_ok;
    logic [2:0]     inc_sat;
    logic [2:0]     round_inc;

    assign conf_edge = confirm_btn & ~conf_q_reg;
    assign lfsr_next = {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
    assign inc_sat   = (inc_reg == 3'd7) ? 3'd7 : inc_reg + 3'd1;
    assign round_inc = round_reg + 3'd1;

    // Rejection sampling: only in-range candidates become the target.
    always_comb begin
        cand    = {6'd0, lfsr_reg[3:0]};
        cand_ok = (lfsr_reg[3:0] < 4'd10);
        case (max_digit)
            2'd2: begin
                cand    = {3'd0, lfsr_reg[6:0]};
                cand_ok = (lfsr_reg[6:0] < 7'd100);
            end
            2'd3: begin
                cand    = lfsr_reg;
                cand_ok = (lfsr_reg < 10'd1000);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            state_reg   <= IDLE;
            lfsr_reg    <= LFSR_SEED;
            presc_reg   <= '0;
            timer_reg   <= '0;
            inc_reg     <= '0;
            round_reg   <= '0;
            target_reg  <= '0;
            guess_reg   <= '0;
            correct_reg <= 1'b0;
            wrong_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            conf_q_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            presc_reg   <= presc_next;
            timer_reg   <= timer_next;
            inc_reg     <= inc_next;
            round_reg   <= round_next;
            target_reg  <= target_next;
            guess_reg   <= guess_next;
            correct_reg <= correct_next;
            wrong_reg   <= wrong_next;
            timeout_reg <= timeout_next;
            conf_q_reg  <= confirm_btn;
        end
    end

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        timer_next   = timer_reg;
        inc_next     = inc_reg;
        round_next   = round_reg;
        target_next  = target_reg;
        guess_next   = guess_reg;
        correct_next = 1'b0;
        wrong_next   = 1'b0;
        timeout_next = timeout_reg;
        if (start) begin
            round_next   = '0;
            inc_next     = '0;
            timeout_next = 1'b0;
            state_next   = LOAD;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (cand_ok) begin
                        target_next = cand;
                        timer_next  = ROUND_TIME_V;
                        presc_next  = '0;
                        state_next  = PLAY;
                    end
                end
                PLAY: begin
                    if (presc_reg == PRESC_MAX) begin
                        presc_next = '0;
                        if (timer_reg != 7'd0)
                            timer_next = timer_reg - 7'd1;
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                    // A confirm in the expiry cycle still gets checked.
                    if (conf_edge) begin
                        guess_next = guess;
                        state_next = CHECK;
                    end else if (timer_reg == 7'd0) begin
                        timeout_next = 1'b1;
                        state_next   = DONE;
                    end
                end
                CHECK: begin
                    if (guess_reg == target_reg) begin
                        correct_next = 1'b1;
                        round_next   = round_inc;
                        state_next   = (round_inc == ROUNDS_V) ? DONE : LOAD;
                    end else begin
                        wrong_next = 1'b1;
                        inc_next   = inc_sat;
                        if (inc_sat >= max_incorrect) begin
                            state_next = DONE;
                        end else if (timer_reg == 7'd0) begin
                            timeout_next = 1'b1;
                            state_next   = DONE;
                        end else begin
                            state_next = PLAY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GUESS_HINT_EN
    logic high_reg, low_reg;

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            high_reg <= 1'b0;
            low_reg  <= 1'b0;
        end else if (start || state_reg == LOAD ||
                     (state_reg == CHECK && guess_reg == target_reg)) begin
            high_reg <= 1'b0;
            low_reg  <= 1'b0;
        end else if (state_reg == CHECK) begin
            high_reg <= (guess_reg > target_reg);
            low_reg  <= (guess_reg < target_reg);
        end
    end

    assign guess_high = high_reg;
    assign guess_low  = low_reg;
`else
    assign guess_high = 1'b0;
    assign guess_low  = 1'b0;
`endif

    assign timer             = timer_reg;
    assign incorrect_guesses = inc_reg;
    assign round             = round_reg;
    assign target            = target_reg;
    assign correct           = correct_reg;
    assign wrong             = wrong_reg;
    assign timeout           = timeout_reg;
    assign busy              = (state_reg == LOAD) || (state_reg == PLAY) || (state_reg == CHECK);
    assign done              = (state_reg == DONE);

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
Round sequencer for the number-guessing datapath. It generates each round's secret target and runs the per-round countdown. It edge-detects the confirm button, compares the player's guess, and counts rounds and incorrect guesses. Its timer, incorrect_guesses and round outputs drive the difficulty FSM, which feeds back max_digit and max_incorrect for the active level.

Parameters:
ROUND_TIME, 30, seconds loaded into timer at each round start (1..127)
TICK_DIV, 50_000_000, clk cycles per 1 s timer tick (sim uses 4)
ROUNDS_PER_LEVEL, 5, correct guesses that complete a level (1..7)
LFSR_SEED, 10'h2A5, LFSR reset value, nonzero

Ports:
clk  in  1  system clock
restart_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: begin or restart a level
max_digit  in  2  digits of the target: 1 → 0..9, 2 → 0..99, 3 → 0..999; 0 is treated as 1
max_incorrect  in  3  wrong guesses allowed before fail
confirm_btn  in  1  synchronous level input from the confirm button; only its rising edge is used
guess  in  10  player guess, binary, sampled on the confirm edge
timer  out  7  seconds remaining
incorrect_guesses  out  3  wrong guesses this level, saturates at 7
round  out  3  correct guesses this level
target  out  10  current secret value
correct  out  1  1-cycle pulse on a correct guess
wrong  out  1  1-cycle pulse on a wrong guess
busy  out  1  high in LOAD, PLAY and CHECK
done  out  1  high in DONE
timeout  out  1  high in DONE when the level ended by timer expiry
guess_high  out  1  hint: last guess was above target
guess_low  out  1  hint: last guess was below target

Behaviour:
- Reset (restart_n=0, asynchronous) values:
  - all outputs 0, state IDLE
  - LFSR=LFSR_SEED, prescaler=0, confirm edge register=0
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1, advances every cycle in every state, never reaches zero.
- Confirm edge: conf_edge = confirm_btn & ~confirm_btn_q. The conf_edge register updates every cycle. Edges outside PLAY are ignored.
- IDLE:
  - start → clear round, incorrect_guesses, timeout and hints; go to LOAD.
- LOAD (rejection sampling):
  - Candidate = lfsr[3:0], lfsr[6:0] or lfsr[9:0] for max_digit 1, 2 or 3.
  - Candidate < 10, 100 or 1000 respectively → target=candidate, timer=ROUND_TIME, prescaler=0, go to PLAY.
  - Otherwise stay in LOAD; next cycle retries with the advanced LFSR.
- PLAY:
  - Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and timer decrements.
  - timer==0 with no conf_edge → timeout=1, go to DONE.
  - conf_edge → latch guess, go to CHECK. This holds even if timer hits 0 in the same cycle; the confirm wins.
- CHECK (exactly 1 cycle, timer frozen):
  - guess==target:
    - correct=1, round+1, hints cleared.
    - New round==ROUNDS_PER_LEVEL → DONE.
    - Otherwise → LOAD.
  - guess!=target:
    - wrong=1, incorrect_guesses+1 (saturating), hints updated.
    - New count ≥ max_incorrect → DONE.
    - Else timer==0 → timeout=1, DONE.
    - Otherwise → PLAY; the prescaler keeps its value.
- DONE: all counters hold; start → clear counters and go to LOAD.
- start in LOAD, PLAY or CHECK: aborts the level. Counters clear and the next state is LOAD. start has priority over every other event.
- Latency:
  - Confirm rising edge to correct/wrong pulse: 2 cycles.
  - start to PLAY: ≥2 cycles.
- Width rules:
  - guess and target are compared as 10-bit unsigned.
  - Guesses ≥1000 are valid inputs and simply count as wrong.

Optional Feature:
GUESS_HINT_EN. When defined, a wrong guess in CHECK registers guess_high=(guess>target) and guess_low=(guess<target). Hints clear on a correct guess, on start, and in LOAD. When undefined, guess_high and guess_low are tied to 0 and no magnitude comparator is built.

Test Plan:
- Reset values: TICK_DIV=4. Pulse start, force LFSR so target=7, max_digit=1. Guess 7 → correct pulse 2 cycles after the edge, round=1, state LOAD.
- Fail on guesses: max_incorrect=3, guesses 3, 4, 5 → wrong pulses, incorrect_guesses=3, done=1, timeout=0. Further confirm edges are ignored.
- Timeout: ROUND_TIME=2, TICK_DIV=4, no confirm → timer 2→1→0 at 4-cycle spacing, then done=1, timeout=1.
- Level complete and range: max_digit=3, 5 correct guesses → round=5, done=1. Every captured target is <1000.
- Simultaneous and abort cases:
  - Confirm edge in the same cycle timer reaches 0 with a wrong guess → wrong=1 then timeout=1.
  - start mid-PLAY → counters cleared, LOAD.
  - restart_n low mid-CHECK → all outputs 0 immediately.
- With GUESS_HINT_EN and target=42: guess 50 → guess_high=1; guess 10 → guess_low=1; guess 42 → both 0. Without the macro both stay 0.
